// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage that sits directly after execute. It issues
//   loads and stores on a data bus that allows one outstanding transaction
//   (request held until acknowledge), aligns and extends load data, and
//   presents a registered single-cycle writeback pulse. Upstream is stalled
//   while a bus transaction is outstanding.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid          execute-stage outputs valid (ignored while stall = 1)
//   ir                instruction word, ir[31:26] selects access size/sign
//   tmp_c             ALU result: effective address or pass-through result
//   tmp_b             store data
//   regaddr           destination register
//   read/write/excp   load flag, store flag, upstream exception
//   stall             upstream must hold its inputs
//   bus_req/bus_we    bus request (held until bus_ack), write enable
//   bus_addr/bus_be   word-aligned address, little-endian byte enables
//   bus_wdata         lane-replicated store data
//   bus_ack/bus_rdata transaction complete, read data valid with bus_ack
//   wb_valid          one-cycle writeback pulse
//   wb_data/wb_regaddr/wb_excp  writeback fields, held between pulses
//
// Build option
//   MEM_ALIGN_EXCP_EN  when defined, misaligned half/word accesses raise an
//                      exception instead of reaching the bus. When undefined,
//                      low address bits that break alignment are ignored.
//
// AW must lie in 3..32; DW is fixed at 32.
// ---------------------------------------------------------------------------

// state | meaning
// ------+--------------------------------------------
// IDLE  | no transaction outstanding, accepts input
// BUSY  | bus request outstanding, waiting for bus_ack

module mem_stage #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   ir,
  input  logic [DW-1:0] tmp_c,
  input  logic [DW-1:0] tmp_b,
  input  logic [4:0]    regaddr,
  input  logic          read,
  input  logic          write,
  input  logic          excp,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data,
  output logic [4:0]    wb_regaddr,
  output logic          wb_excp
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  state_t r_state;
  state_t w_next_state;

  // Captured at accept, used when the load data returns.
  size_t       r_size;
  logic [1:0]  r_lane;
  logic        r_signed;
  logic        r_is_load;
  logic [4:0]  r_regaddr;
  logic [DW-1:0] r_tmp_c;

  logic [5:0]    w_op;
  size_t         w_size;
  logic          w_signed;
  logic          w_excp_in;
  logic          w_mem;
  logic          w_misalign;
  logic          w_accept;
  logic          w_go_bus;
  logic          w_wb_excp;
  logic [3:0]    w_be;
  logic [DW-1:0] w_wdata;
  logic [7:0]    w_ld_byte;
  logic [15:0]   w_ld_half;
  logic [DW-1:0] w_ld_data;
  logic          w_unused;

  assign w_unused = ^ir[25:0];

  // -------------------------------------------------------------------------
  // Instruction decode
  // -------------------------------------------------------------------------
  assign w_op = ir[31:26];

  always_comb begin
    w_size   = SZ_WORD;
    w_signed = 1'b0;
    case (w_op)
      OP_LB:         begin w_size = SZ_BYTE; w_signed = 1'b1; end
      OP_LBU, OP_SB: w_size = SZ_BYTE;
      OP_LH:         begin w_size = SZ_HALF; w_signed = 1'b1; end
      OP_LHU, OP_SH: w_size = SZ_HALF;
      OP_LW, OP_SW:  w_size = SZ_WORD;
      default:       w_size = SZ_WORD;
    endcase
  end

  // A simultaneous read and write request is meaningless and is reported
  // to commit exactly like an upstream exception.
  assign w_excp_in = excp | (read & write);
  assign w_mem     = (read | write) & ~w_excp_in;

`ifdef MEM_ALIGN_EXCP_EN
  always_comb begin
    w_misalign = 1'b0;
    if (w_mem) begin
      case (w_size)
        SZ_HALF: w_misalign = tmp_c[0];
        SZ_WORD: w_misalign = |tmp_c[1:0];
        default: w_misalign = 1'b0;
      endcase
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept  = (r_state == IDLE) & in_valid;
  assign w_go_bus  = w_accept & w_mem & ~w_misalign;
  assign w_wb_excp = w_excp_in | w_misalign;

  // Byte enables and lane replication. Half accesses use a[1] only, so an
  // unaligned half rounds down to its containing halfword.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = tmp_b;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << tmp_c[1:0];
        w_wdata = {4{tmp_b[7:0]}};
      end
      SZ_HALF: begin
        w_be    = tmp_c[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{tmp_b[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = tmp_b;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load data alignment and extension
  // -------------------------------------------------------------------------
  assign w_ld_byte = bus_rdata[{r_lane, 3'b000} +: 8];
  assign w_ld_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_ld_data = bus_rdata;
    case (r_size)
      SZ_BYTE: w_ld_data = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: w_ld_data = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = bus_rdata;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_go_bus) w_next_state = BUSY;
      BUSY:    if (bus_ack)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall = (r_state == BUSY);
  end

  // -------------------------------------------------------------------------
  // Bus and writeback registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_regaddr <= '0;
      wb_excp    <= 1'b0;
      r_size     <= SZ_WORD;
      r_lane     <= '0;
      r_signed   <= 1'b0;
      r_is_load  <= 1'b0;
      r_regaddr  <= '0;
      r_tmp_c    <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (w_go_bus) begin
        bus_req   <= 1'b1;
        bus_we    <= write;
        bus_addr  <= {tmp_c[AW-1:2], 2'b00};
        bus_be    <= w_be;
        bus_wdata <= w_wdata;
        r_size    <= w_size;
        r_lane    <= tmp_c[1:0];
        r_signed  <= w_signed;
        r_is_load <= read;
        r_regaddr <= regaddr;
        r_tmp_c   <= tmp_c;
      end else if (w_accept) begin
        // No bus traffic: ALU pass-through, exception or misaligned access.
        wb_valid   <= 1'b1;
        wb_data    <= tmp_c;
        wb_regaddr <= w_wb_excp ? 5'd0 : regaddr;
        wb_excp    <= w_wb_excp;
      end else if ((r_state == BUSY) && bus_ack) begin
        bus_req    <= 1'b0;
        bus_we     <= 1'b0;
        wb_valid   <= 1'b1;
        wb_excp    <= 1'b0;
        wb_data    <= r_is_load ? w_ld_data : r_tmp_c;
        wb_regaddr <= r_is_load ? r_regaddr : 5'd0;
      end
    end
  end

endmodule
